// File: rtl/sd_wishbone_burst.sv
// sd_wishbone_burst
//   Wishbone B4 DMA master that moves one SD data block between the SD manager's
//   block buffers and system memory using incrementing bursts.
//
// Ports
//   clk_50, reset_n            single clock, asynchronous active-low reset
//   ext_read_act/addr/go/stop  read handshake (memory -> read buffer)
//   ext_write_act/addr/done    write handshake (write buffer -> memory)
//   ext_err                    one-cycle pulse when a transfer is aborted by wbm_err_i
//   bram_rd_ext_*              write port of the read buffer
//   bram_wr_ext_addr/q         read port of the write buffer (1-cycle latency)
//   wbm_*                      Wishbone B4 master
module sd_wishbone_burst #(
    parameter int unsigned DW          = 32,
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned BURST_LEN   = 8,
    localparam int unsigned AW         = $clog2(BLOCK_BYTES / (DW / 8))
) (
    input  logic            clk_50,
    input  logic            reset_n,
    input  logic            ext_read_act,
    input  logic [31:0]     ext_read_addr,
    output logic            ext_read_go,
    input  logic            ext_read_stop,
    input  logic            ext_write_act,
    input  logic [31:0]     ext_write_addr,
    output logic            ext_write_done,
    output logic            ext_err,
    output logic            bram_rd_ext_clk,
    output logic [AW-1:0]   bram_rd_ext_addr,
    output logic            bram_rd_ext_wren,
    output logic [DW-1:0]   bram_rd_ext_data,
    output logic            bram_wr_ext_clk,
    output logic [AW-1:0]   bram_wr_ext_addr,
    input  logic [DW-1:0]   bram_wr_ext_q,
    output logic            wbm_clk_o,
    output logic [31:0]     wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [2:0]      wbm_cti_o,
    output logic [1:0]      wbm_bte_o,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i
);

    localparam int unsigned WORDS      = BLOCK_BYTES / (DW / 8);
    localparam int unsigned BLK_SHIFT  = $clog2(BLOCK_BYTES);
    localparam int unsigned BYTE_SHIFT = $clog2(DW / 8);
    localparam logic [AW:0]   LAST_WORD  = (AW + 1)'(WORDS - 1);
    localparam logic [AW-1:0] BURST_MASK = AW'(BURST_LEN - 1);

    typedef enum logic [3:0] {
        StIdle,
        StRdBurst,
        StRdGap,
        StRdDone,
        StWrPrime,
        StWrBurst,
        StWrGap,
        StWrDone,
        StErr
    } state_e;

    state_e        state_q, state_d;
    logic [AW:0]   word_cnt_q, word_cnt_d;
    logic [31:0]   block_addr_q, block_addr_d;
    logic          rd_act_last_q, wr_act_last_q;
    logic          write_done_q, write_done_d;
    logic          read_go_q, read_go_d;
    logic          rd_wren_q, rd_wren_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic rd_start, wr_start;
    logic in_burst, last_in_burst, last_in_block, beat_ok;

    assign bram_rd_ext_clk = clk_50;
    assign bram_wr_ext_clk = clk_50;
    assign wbm_clk_o       = clk_50;

    assign rd_start      = ext_read_act & ~rd_act_last_q;
    assign wr_start      = ext_write_act & ~wr_act_last_q;
    assign in_burst      = (state_q == StRdBurst) || (state_q == StWrBurst);
    // Bursts are aligned to BURST_LEN words, so the low bits of word_cnt give the beat index.
    assign last_in_burst = (word_cnt_q[AW-1:0] & BURST_MASK) == BURST_MASK;
    assign last_in_block = word_cnt_q == LAST_WORD;
    // An err beat is never counted, even if ack is also high.
    assign beat_ok       = wbm_ack_i & ~wbm_err_i;

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        block_addr_d = block_addr_q;
        write_done_d = write_done_q;
        unique case (state_q)
            StIdle: begin
                // Read has priority; a simultaneous write edge is lost.
                if (rd_start) begin
                    block_addr_d = ext_read_addr;
                    word_cnt_d   = '0;
                    state_d      = StRdBurst;
                end else if (wr_start) begin
                    block_addr_d = ext_write_addr;
                    word_cnt_d   = '0;
                    write_done_d = 1'b0;
                    state_d      = StWrPrime;
                end
            end
            StRdBurst, StWrBurst: begin
                if (wbm_err_i) begin
                    state_d = StErr;
                end else if (wbm_ack_i) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (last_in_block) begin
                        state_d = (state_q == StRdBurst) ? StRdDone : StWrDone;
                    end else if (last_in_burst) begin
                        state_d = (state_q == StRdBurst) ? StRdGap : StWrGap;
                    end
                end
            end
            StRdGap:   state_d = StRdBurst;
            StWrGap:   state_d = StWrBurst;
            StWrPrime: state_d = StWrBurst;
            StRdDone: begin
                if (ext_read_stop) begin
                    state_d = StIdle;
                end
            end
            StWrDone: begin
                write_done_d = 1'b1;
                state_d      = StIdle;
            end
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read-buffer write is delayed one cycle behind the ack that delivered the word.
    always_comb begin
        rd_wren_d = (state_q == StRdBurst) & beat_ok;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (rd_wren_d) begin
            rd_addr_d = word_cnt_q[AW-1:0];
            rd_data_d = wbm_dat_i;
        end
        read_go_d = (state_q == StRdDone) & ~ext_read_stop;
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            word_cnt_q    <= '0;
            block_addr_q  <= '0;
            rd_act_last_q <= 1'b0;
            wr_act_last_q <= 1'b0;
            write_done_q  <= 1'b0;
            read_go_q     <= 1'b0;
            rd_wren_q     <= 1'b0;
            rd_addr_q     <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            block_addr_q  <= block_addr_d;
            rd_act_last_q <= ext_read_act;
            wr_act_last_q <= ext_write_act;
            write_done_q  <= write_done_d;
            read_go_q     <= read_go_d;
            rd_wren_q     <= rd_wren_d;
            rd_addr_q     <= rd_addr_d;
            rd_data_q     <= rd_data_d;
        end
    end

    always_comb begin
        wbm_cyc_o = in_burst;
        wbm_stb_o = in_burst;
        wbm_we_o  = state_q == StWrBurst;
        wbm_sel_o = in_burst ? '1 : '0;
        wbm_bte_o = 2'b00;
        wbm_dat_o = (state_q == StWrBurst) ? bram_wr_ext_q : '0;
        wbm_cti_o = 3'b000;
        if (in_burst && (BURST_LEN > 1)) begin
            wbm_cti_o = last_in_burst ? 3'b111 : 3'b010;
        end
        wbm_adr_o = (block_addr_q << BLK_SHIFT) + (32'(word_cnt_q) << BYTE_SHIFT);
        // Look one word ahead on ack so q already holds the next beat's data.
        bram_wr_ext_addr = word_cnt_q[AW-1:0]
                         + AW'(wbm_ack_i & (state_q == StWrBurst));
    end

    assign bram_rd_ext_wren = rd_wren_q;
    assign bram_rd_ext_addr = rd_addr_q;
    assign bram_rd_ext_data = rd_data_q;
    assign ext_read_go      = read_go_q;
    assign ext_write_done   = write_done_q;
    assign ext_err          = state_q == StErr;

endmodule

// File: tb/tb_sd_wishbone_burst.sv
// Bench for sd_wishbone_burst: a main instance (DW=32, 512 B, BURST_LEN=8) against a
// memory/slave model with random wait states and error injection, plus two small
// instances for the DW=64/BURST_LEN=4 and BURST_LEN=1 configurations.
module tb_sd_wishbone_burst;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_pass = 0;
    int n_chk  = 0;

    logic [31:0] mem_seed = 32'h1234_5678;
    logic [31:0] wr_seed  = 32'h0bad_f00d;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ mem_seed, (a * 32'h9E37_79B1) ^ ~mem_seed};
    endfunction
    function automatic logic [31:0] mem_lo(input logic [31:0] a);
        logic [63:0] w;
        w = mem_word(a);
        return w[31:0];
    endfunction
    function automatic logic [31:0] wbuf_word(input logic [6:0] idx);
        return (32'(idx) * 32'h0100_0193) ^ wr_seed;
    endfunction

    // ---------------- main instance ----------------
    logic        m_rd_act = 0, m_rd_stop = 0, m_wr_act = 0;
    logic [31:0] m_rd_blk = 0, m_wr_blk = 0;
    logic        m_go, m_done, m_ext_err, m_rd_clk, m_wr_clk, m_wb_clk;
    logic [6:0]  m_rd_addr, m_wr_addr;
    logic        m_rd_wren;
    logic [31:0] m_rd_data, m_wr_q, m_adr, m_dat_o, m_dat_i;
    logic [3:0]  m_sel;
    logic        m_cyc, m_stb, m_we, m_ack, m_err;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;

    sd_wishbone_burst #(.DW(32), .BLOCK_BYTES(512), .BURST_LEN(8)) u_main (
        .clk_50(clk), .reset_n(rst_n),
        .ext_read_act(m_rd_act), .ext_read_addr(m_rd_blk), .ext_read_go(m_go),
        .ext_read_stop(m_rd_stop), .ext_write_act(m_wr_act), .ext_write_addr(m_wr_blk),
        .ext_write_done(m_done), .ext_err(m_ext_err),
        .bram_rd_ext_clk(m_rd_clk), .bram_rd_ext_addr(m_rd_addr),
        .bram_rd_ext_wren(m_rd_wren), .bram_rd_ext_data(m_rd_data),
        .bram_wr_ext_clk(m_wr_clk), .bram_wr_ext_addr(m_wr_addr), .bram_wr_ext_q(m_wr_q),
        .wbm_clk_o(m_wb_clk), .wbm_adr_o(m_adr), .wbm_dat_o(m_dat_o), .wbm_dat_i(m_dat_i),
        .wbm_sel_o(m_sel), .wbm_cyc_o(m_cyc), .wbm_stb_o(m_stb), .wbm_we_o(m_we),
        .wbm_cti_o(m_cti), .wbm_bte_o(m_bte), .wbm_ack_i(m_ack), .wbm_err_i(m_err)
    );

    // Slave model: random wait states, error injected when beat_total reaches err_at.
    int unsigned wait_left = 0;
    int unsigned max_wait  = 0;
    int          beat_total = 0;
    int          err_at     = -1;
    int          cyc_n      = 0;
    logic [31:0] log_adr  [4096];
    logic [31:0] log_wdat [4096];
    logic [2:0]  log_cti  [4096];
    logic        log_we   [4096];
    int          log_cyc  [4096];

    always_comb begin
        m_ack   = m_cyc & m_stb & (wait_left == 0) & (beat_total != err_at);
        m_err   = m_cyc & m_stb & (wait_left == 0) & (beat_total == err_at);
        m_dat_i = m_we ? 32'h0 : mem_lo(m_adr);
    end

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (m_cyc && m_stb) begin
            if (wait_left == 0) begin
                if (m_ack) begin
                    log_adr[beat_total]  <= m_adr;
                    log_wdat[beat_total] <= m_dat_o;
                    log_cti[beat_total]  <= m_cti;
                    log_we[beat_total]   <= m_we;
                    log_cyc[beat_total]  <= cyc_n;
                    beat_total           <= beat_total + 1;
                end
                wait_left <= $urandom_range(max_wait, 0);
            end else begin
                wait_left <= wait_left - 1;
            end
        end
    end

    // Read buffer and write buffer models.
    logic [31:0] rd_buf [128];
    logic [6:0]  rd_log [4096];
    int          rd_total = 0;
    always @(posedge clk) begin
        if (m_rd_wren) begin
            rd_buf[m_rd_addr] <= m_rd_data;
            rd_log[rd_total]  <= m_rd_addr;
            rd_total          <= rd_total + 1;
        end
        m_wr_q <= wbuf_word(m_wr_addr);
    end

    // ---------------- DW=64, BURST_LEN=4, 128-byte instance ----------------
    logic        s64_act = 0, s64_stop = 0;
    logic [31:0] s64_blk = 0;
    logic        s64_go, s64_done, s64_eerr, s64_c0, s64_c1, s64_c2, s64_wren;
    logic        s64_cyc, s64_stb, s64_we, s64_ack;
    logic [3:0]  s64_rd_addr, s64_wr_addr;
    logic [63:0] s64_rd_data, s64_dat_o, s64_dat_i;
    logic [31:0] s64_adr;
    logic [7:0]  s64_sel;
    logic [2:0]  s64_cti;
    logic [1:0]  s64_bte;
    always_comb begin
        s64_ack   = s64_cyc & s64_stb;
        s64_dat_i = mem_word(s64_adr);
    end

    sd_wishbone_burst #(.DW(64), .BLOCK_BYTES(128), .BURST_LEN(4)) u_w64 (
        .clk_50(clk), .reset_n(rst_n),
        .ext_read_act(s64_act), .ext_read_addr(s64_blk), .ext_read_go(s64_go),
        .ext_read_stop(s64_stop), .ext_write_act(1'b0), .ext_write_addr(32'h0),
        .ext_write_done(s64_done), .ext_err(s64_eerr),
        .bram_rd_ext_clk(s64_c0), .bram_rd_ext_addr(s64_rd_addr),
        .bram_rd_ext_wren(s64_wren), .bram_rd_ext_data(s64_rd_data),
        .bram_wr_ext_clk(s64_c1), .bram_wr_ext_addr(s64_wr_addr), .bram_wr_ext_q(64'h0),
        .wbm_clk_o(s64_c2), .wbm_adr_o(s64_adr), .wbm_dat_o(s64_dat_o),
        .wbm_dat_i(s64_dat_i), .wbm_sel_o(s64_sel), .wbm_cyc_o(s64_cyc),
        .wbm_stb_o(s64_stb), .wbm_we_o(s64_we), .wbm_cti_o(s64_cti), .wbm_bte_o(s64_bte),
        .wbm_ack_i(s64_ack), .wbm_err_i(1'b0)
    );

    // ---------------- BURST_LEN=1 (classic), 64-byte instance ----------------
    logic        s1_act = 0, s1_stop = 0;
    logic [31:0] s1_blk = 0;
    logic        s1_go, s1_done, s1_eerr, s1_c0, s1_c1, s1_c2, s1_wren;
    logic        s1_cyc, s1_stb, s1_we, s1_ack;
    logic [3:0]  s1_rd_addr, s1_wr_addr;
    logic [31:0] s1_rd_data, s1_dat_o, s1_dat_i, s1_adr;
    logic [3:0]  s1_sel;
    logic [2:0]  s1_cti;
    logic [1:0]  s1_bte;
    always_comb begin
        s1_ack   = s1_cyc & s1_stb;
        s1_dat_i = mem_lo(s1_adr);
    end

    sd_wishbone_burst #(.DW(32), .BLOCK_BYTES(64), .BURST_LEN(1)) u_cls (
        .clk_50(clk), .reset_n(rst_n),
        .ext_read_act(s1_act), .ext_read_addr(s1_blk), .ext_read_go(s1_go),
        .ext_read_stop(s1_stop), .ext_write_act(1'b0), .ext_write_addr(32'h0),
        .ext_write_done(s1_done), .ext_err(s1_eerr),
        .bram_rd_ext_clk(s1_c0), .bram_rd_ext_addr(s1_rd_addr),
        .bram_rd_ext_wren(s1_wren), .bram_rd_ext_data(s1_rd_data),
        .bram_wr_ext_clk(s1_c1), .bram_wr_ext_addr(s1_wr_addr), .bram_wr_ext_q(32'h0),
        .wbm_clk_o(s1_c2), .wbm_adr_o(s1_adr), .wbm_dat_o(s1_dat_o),
        .wbm_dat_i(s1_dat_i), .wbm_sel_o(s1_sel), .wbm_cyc_o(s1_cyc),
        .wbm_stb_o(s1_stb), .wbm_we_o(s1_we), .wbm_cti_o(s1_cti), .wbm_bte_o(s1_bte),
        .wbm_ack_i(s1_ack), .wbm_err_i(1'b0)
    );

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({m_cyc, m_stb, m_we, m_go, m_done, m_ext_err, m_rd_wren} !== 7'b0)
            $display("FAIL reset_ctrl: got %b required 0", {m_cyc, m_stb, m_we, m_go,
                     m_done, m_ext_err, m_rd_wren});
        else n_pass++;
        n_chk++;
        if ({m_adr, m_rd_addr, m_wr_addr, m_sel, m_cti} !== 53'b0)
            $display("FAIL reset_addr: adr %h rd %h wr %h sel %h cti %h required 0",
                     m_adr, m_rd_addr, m_wr_addr, m_sel, m_cti);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read(input logic [31:0] blk, input int unsigned maxw,
                             input string tag);
        int b0, r0, c, aerr, cerr, gerr, derr, herr;
        logic [31:0] base;
        base = blk << 9;
        mem_seed = $urandom;
        max_wait = maxw;
        @(negedge clk);
        b0 = beat_total; r0 = rd_total;
        m_rd_blk = blk; m_rd_act = 1'b1;
        @(negedge clk);
        m_rd_act = 1'b0;
        n_chk++;
        if (m_cyc !== 1'b1) $display("FAIL %s_latency: cyc %b required 1", tag, m_cyc);
        else n_pass++;
        for (c = 0; c < 3000 && m_go !== 1'b1; c++) @(negedge clk);
        n_chk++;
        if (m_go !== 1'b1) $display("FAIL %s_go: got %b required 1", tag, m_go);
        else n_pass++;
        n_chk++;
        if (beat_total - b0 !== 128)
            $display("FAIL %s_beats: got %0d required 128", tag, beat_total - b0);
        else n_pass++;
        aerr = 0; cerr = 0; gerr = 0; derr = 0;
        for (int i = 0; i < 128; i++) begin
            if (log_adr[b0 + i] !== base + (32'(i) << 2) || log_we[b0 + i] !== 1'b0) aerr++;
            if (log_cti[b0 + i] !== ((i % 8 == 7) ? 3'b111 : 3'b010)) cerr++;
            if (i > 0 && (log_cyc[b0 + i] - log_cyc[b0 + i - 1]) != ((i % 8 == 0) ? 2 : 1))
                gerr++;
            if (rd_buf[i] !== mem_lo(base + (32'(i) << 2))) derr++;
        end
        n_chk++;
        if (aerr != 0) $display("FAIL %s_addr: %0d bad beats required 0", tag, aerr);
        else n_pass++;
        n_chk++;
        if (cerr != 0) $display("FAIL %s_cti: %0d bad beats required 0", tag, cerr);
        else n_pass++;
        if (maxw == 0) begin
            n_chk++;
            if (gerr != 0) $display("FAIL %s_gap: %0d bad spacings required 0", tag, gerr);
            else n_pass++;
        end
        n_chk++;
        if (rd_total - r0 !== 128 || derr != 0)
            $display("FAIL %s_bram: writes %0d bad %0d required 128/0", tag,
                     rd_total - r0, derr);
        else n_pass++;
        herr = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_go !== 1'b1 || m_cyc !== 1'b0) herr++;
        end
        n_chk++;
        if (herr != 0) $display("FAIL %s_go_hold: %0d bad cycles required 0", tag, herr);
        else n_pass++;
        m_rd_stop = 1'b1;
        @(negedge clk);
        m_rd_stop = 1'b0;
        n_chk++;
        if (m_go !== 1'b0) $display("FAIL %s_go_fall: got %b required 0", tag, m_go);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int b0, c, wb;
        mem_seed = $urandom;
        max_wait = 0;
        @(negedge clk);
        b0 = beat_total;
        m_rd_blk = 32'd2; m_wr_blk = 32'd4;
        m_rd_act = 1'b1; m_wr_act = 1'b1;
        @(negedge clk);
        m_rd_act = 1'b0; m_wr_act = 1'b0;
        n_chk++;
        if (m_cyc !== 1'b1 || m_we !== 1'b0 || m_adr !== 32'h400)
            $display("FAIL simul_start: cyc %b we %b adr %h required 1 0 00000400",
                     m_cyc, m_we, m_adr);
        else n_pass++;
        for (c = 0; c < 3000 && m_go !== 1'b1; c++) @(negedge clk);
        wb = 0;
        for (int i = 0; i < beat_total - b0; i++) if (log_we[b0 + i] !== 1'b0) wb++;
        n_chk++;
        if (m_go !== 1'b1 || beat_total - b0 !== 128 || wb != 0)
            $display("FAIL simul_read: go %b beats %0d writes %0d required 1/128/0",
                     m_go, beat_total - b0, wb);
        else n_pass++;
        m_rd_stop = 1'b1;
        @(negedge clk);
        m_rd_stop = 1'b0;
        c = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_cyc !== 1'b0 || m_done !== 1'b0) c++;
        end
        n_chk++;
        if (c != 0) $display("FAIL simul_write_dropped: %0d bad cycles required 0", c);
        else n_pass++;
    endtask

    task automatic test_write(input logic [31:0] blk, input string tag);
        int b0, c, aerr, derr;
        logic [31:0] base;
        base = blk << 9;
        wr_seed = $urandom;
        max_wait = 3;
        @(negedge clk);
        b0 = beat_total;
        m_wr_blk = blk; m_wr_act = 1'b1;
        @(negedge clk);
        m_wr_act = 1'b0;
        n_chk++;
        if (m_done !== 1'b0 || m_cyc !== 1'b0)
            $display("FAIL %s_prime: done %b cyc %b required 0 0", tag, m_done, m_cyc);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (m_cyc !== 1'b1 || m_we !== 1'b1)
            $display("FAIL %s_latency: cyc %b we %b required 1 1", tag, m_cyc, m_we);
        else n_pass++;
        for (c = 0; c < 3000 && m_done !== 1'b1; c++) @(negedge clk);
        n_chk++;
        if (m_done !== 1'b1 || beat_total - b0 !== 128)
            $display("FAIL %s_done: done %b beats %0d required 1/128", tag, m_done,
                     beat_total - b0);
        else n_pass++;
        aerr = 0; derr = 0;
        for (int i = 0; i < 128; i++) begin
            if (log_adr[b0 + i] !== base + (32'(i) << 2) || log_we[b0 + i] !== 1'b1) aerr++;
            if (log_wdat[b0 + i] !== wbuf_word(7'(i))) derr++;
        end
        n_chk++;
        if (aerr != 0) $display("FAIL %s_addr: %0d bad beats required 0", tag, aerr);
        else n_pass++;
        n_chk++;
        if (derr != 0) $display("FAIL %s_data: %0d bad words required 0", tag, derr);
        else n_pass++;
    endtask

    task automatic test_error();
        int b0, r0, c, go_seen, aerr;
        mem_seed = $urandom;
        max_wait = 0;
        @(negedge clk);
        b0 = beat_total; r0 = rd_total;
        err_at = beat_total + 37;
        m_rd_blk = 32'd5; m_rd_act = 1'b1;
        @(negedge clk);
        m_rd_act = 1'b0;
        go_seen = 0;
        for (c = 0; c < 500 && m_ext_err !== 1'b1; c++) begin
            @(negedge clk);
            if (m_go === 1'b1) go_seen = 1;
        end
        err_at = -1;
        n_chk++;
        if (m_ext_err !== 1'b1 || m_cyc !== 1'b0)
            $display("FAIL err_pulse: ext_err %b cyc %b required 1 0", m_ext_err, m_cyc);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (m_ext_err !== 1'b0) $display("FAIL err_width: got %b required 0", m_ext_err);
        else n_pass++;
        repeat (3) begin
            @(negedge clk);
            if (m_go === 1'b1 || m_cyc === 1'b1) go_seen = 1;
        end
        n_chk++;
        if (go_seen != 0) $display("FAIL err_no_go: go/cyc seen %0d required 0", go_seen);
        else n_pass++;
        aerr = 0;
        for (int i = 0; i < rd_total - r0; i++) if (rd_log[r0 + i] !== 7'(i)) aerr++;
        n_chk++;
        if (rd_total - r0 !== 37 || aerr != 0 || beat_total - b0 !== 37)
            $display("FAIL err_bram: writes %0d bad %0d beats %0d required 37/0/37",
                     rd_total - r0, aerr, beat_total - b0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int b0, c;
        mem_seed = $urandom;
        max_wait = 0;
        @(negedge clk);
        b0 = beat_total;
        m_rd_blk = 32'd7; m_rd_act = 1'b1;
        @(negedge clk);
        m_rd_act = 1'b0;
        for (c = 0; c < 300 && beat_total - b0 < 20; c++) @(negedge clk);
        n_chk++;
        if (m_cyc !== 1'b1) $display("FAIL rstmid_busy: cyc %b required 1", m_cyc);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({m_cyc, m_stb, m_we, m_go, m_done, m_ext_err, m_rd_wren} !== 7'b0)
            $display("FAIL rstmid_ctrl: got %b required 0", {m_cyc, m_stb, m_we, m_go,
                     m_done, m_ext_err, m_rd_wren});
        else n_pass++;
        n_chk++;
        if ({m_adr, m_rd_addr, m_wr_addr, m_sel, m_cti, m_rd_data} !== 85'b0)
            $display("FAIL rstmid_addr: adr %h rd %h wr %h sel %h cti %h data %h required 0",
                     m_adr, m_rd_addr, m_wr_addr, m_sel, m_cti, m_rd_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (m_cyc !== 1'b0) $display("FAIL rstmid_idle: cyc %b required 0", m_cyc);
        else n_pass++;
    endtask

    task automatic test_sweep64();
        int k, last, wcnt, aerr, cerr, gerr, derr;
        logic [31:0] base;
        base = 32'd9 * 32'd128;
        mem_seed = $urandom;
        k = 0; last = 0; wcnt = 0; aerr = 0; cerr = 0; gerr = 0; derr = 0;
        @(negedge clk);
        s64_blk = 32'd9; s64_act = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            s64_act = 1'b0;
            if (s64_go === 1'b1) break;
            if (s64_cyc === 1'b1) begin
                if (s64_adr !== base + (32'(k) << 3) || s64_sel !== 8'hFF) aerr++;
                if (s64_cti !== ((k % 4 == 3) ? 3'b111 : 3'b010)) cerr++;
                if (k > 0 && (c - last) != ((k % 4 == 0) ? 2 : 1)) gerr++;
                last = c;
                k++;
            end
            if (s64_wren === 1'b1) begin
                wcnt++;
                if (s64_rd_data !== mem_word(base + (32'(s64_rd_addr) << 3))) derr++;
            end
        end
        n_chk++;
        if (s64_go !== 1'b1 || k != 16 || wcnt != 16)
            $display("FAIL w64_count: go %b beats %0d writes %0d required 1/16/16",
                     s64_go, k, wcnt);
        else n_pass++;
        n_chk++;
        if (aerr + cerr + gerr + derr != 0)
            $display("FAIL w64_beats: addr %0d cti %0d gap %0d data %0d required all 0",
                     aerr, cerr, gerr, derr);
        else n_pass++;
        s64_stop = 1'b1;
        @(negedge clk);
        s64_stop = 1'b0;
    endtask

    task automatic test_classic();
        int k, last, wcnt, aerr, cerr, gerr, derr;
        logic [31:0] base;
        base = 32'd5 * 32'd64;
        mem_seed = $urandom;
        k = 0; last = 0; wcnt = 0; aerr = 0; cerr = 0; gerr = 0; derr = 0;
        @(negedge clk);
        s1_blk = 32'd5; s1_act = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            s1_act = 1'b0;
            if (s1_go === 1'b1) break;
            if (s1_cyc === 1'b1) begin
                if (s1_adr !== base + (32'(k) << 2)) aerr++;
                if (s1_cti !== 3'b000) cerr++;
                if (k > 0 && (c - last) != 2) gerr++;
                last = c;
                k++;
            end
            if (s1_wren === 1'b1) begin
                wcnt++;
                if (s1_rd_data !== mem_lo(base + (32'(s1_rd_addr) << 2))) derr++;
            end
        end
        n_chk++;
        if (s1_go !== 1'b1 || k != 16 || wcnt != 16)
            $display("FAIL classic_count: go %b beats %0d writes %0d required 1/16/16",
                     s1_go, k, wcnt);
        else n_pass++;
        n_chk++;
        if (aerr + cerr + gerr + derr != 0)
            $display("FAIL classic_beats: addr %0d cti %0d gap %0d data %0d required all 0",
                     aerr, cerr, gerr, derr);
        else n_pass++;
        s1_stop = 1'b1;
        @(negedge clk);
        s1_stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read(32'd3, 0, "rd_blk3");
        test_simultaneous();
        test_write(32'd1, "wr_blk1");
        test_write(32'd2, "wr_blk2");
        test_error();
        test_read(32'd6, 0, "rd_after_err");
        test_reset_mid();
        test_read(32'd7, 1, "rd_after_reset");
        test_sweep64();
        test_classic();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
